// File: rtl/warmboot_ctrl_if.sv
// Switch-matrix and loader signal bundle for the S_WARMBOOT warm-boot controller.
// master: switch matrix / loader side, slave: warmboot_ctrl.
interface warmboot_ctrl_if;
   logic       BOOT;
   logic [3:0] SLOT;
   logic       cfg_ack;
   logic       cfg_req;
   logic [3:0] cfg_slot;
   logic       RESET_FABRIC;
   logic       busy;
   logic       err;

   modport master (
      output BOOT, SLOT, cfg_ack,
      input  cfg_req, cfg_slot, RESET_FABRIC, busy, err
   );

   modport slave (
      input  BOOT, SLOT, cfg_ack,
      output cfg_req, cfg_slot, RESET_FABRIC, busy, err
   );
endinterface

// File: rtl/warmboot_ctrl.sv
// Warm-boot controller: qualifies BOOT, latches SLOT, handshakes with the loader, then pulses fabric reset.
// Optional macro WARMBOOT_SLOT_CHECK_EN rejects out-of-range slots and raises a sticky err.
module warmboot_ctrl #(
   parameter int SYNC_STAGES  = 2,
   parameter int HOLD_CYCLES  = 4,
   parameter int RESET_CYCLES = 16,
   parameter int NUM_SLOTS    = 4
) (
   input logic            CLK,
   input logic            RESET,
   warmboot_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ARM      = 3'd1,
      ST_REQ      = 3'd2,
      ST_RST      = 3'd3,
      ST_WAIT_LOW = 3'd4
   } state_e;

   localparam int CNT_MAX = (HOLD_CYCLES > RESET_CYCLES) ? HOLD_CYCLES : RESET_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES);
   localparam logic [CW-1:0] RST_LAST  = CW'(RESET_CYCLES - 1);
   localparam logic [4:0]    SLOT_LIM  = 5'(NUM_SLOTS);

`ifdef WARMBOOT_SLOT_CHECK_EN
   localparam logic SLOT_CHECK = 1'b1;
`else
   localparam logic SLOT_CHECK = 1'b0;
`endif

   logic [SYNC_STAGES-1:0] boot_sync_q;
   logic [3:0]             slot_sync_q [SYNC_STAGES];
   logic                   boot_s;
   logic [3:0]             slot_s;
   logic                   slot_bad_s;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    slot_q, slot_d;
   logic          err_q, err_d;
   logic          req_q, req_d;
   logic          fab_q, fab_d;
   logic          busy_q, busy_d;

   // Synchronizer chains for the asynchronous BOOT and SLOT nets
   always_ff @(posedge CLK) begin
      if (RESET) begin
         boot_sync_q <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            slot_sync_q[i] <= 4'd0;
         end
      end else begin
         boot_sync_q    <= {boot_sync_q[SYNC_STAGES-2:0], bus.BOOT};
         slot_sync_q[0] <= bus.SLOT;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            slot_sync_q[i] <= slot_sync_q[i-1];
         end
      end
   end

   assign boot_s     = boot_sync_q[SYNC_STAGES-1];
   assign slot_s     = slot_sync_q[SYNC_STAGES-1];
   assign slot_bad_s = ({1'b0, slot_s} >= SLOT_LIM);

   // Next-state and next-output decode; outputs are derived from the next state so they can be registered
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      slot_d  = slot_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (boot_s) begin
               state_d = ST_ARM;
               cnt_d   = CW'(1);
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ARM: begin
            if (!boot_s) begin
               state_d = ST_IDLE;
            end else if (cnt_q == HOLD_LAST) begin
               if (SLOT_CHECK && slot_bad_s) begin
                  err_d   = 1'b1;
                  state_d = ST_WAIT_LOW;
               end else begin
                  slot_d  = slot_s;
                  state_d = ST_REQ;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_REQ: begin
            if (bus.cfg_ack) begin
               state_d = ST_RST;
               cnt_d   = '0;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_RST: begin
            if (cnt_q == RST_LAST) begin
               state_d = ST_WAIT_LOW;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_WAIT_LOW: begin
            // A BOOT still held high must drop before another request can start
            if (!boot_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT_LOW;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      req_d  = (state_d == ST_REQ);
      fab_d  = (state_d == ST_REQ) || (state_d == ST_RST);
      busy_d = (state_d != ST_IDLE);
   end

   // State, counter and registered outputs
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         slot_q  <= 4'd0;
         err_q   <= 1'b0;
         req_q   <= 1'b0;
         fab_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         slot_q  <= slot_d;
         err_q   <= err_d;
         req_q   <= req_d;
         fab_q   <= fab_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.cfg_req      = req_q;
   assign bus.cfg_slot     = slot_q;
   assign bus.RESET_FABRIC = fab_q;
   assign bus.busy         = busy_q;
   assign bus.err          = err_q;

endmodule

// File: tb/tb_warmboot_ctrl.sv
// Scoreboard bench for warmboot_ctrl: expected output edges are queued by the stimulus and
// checked by a monitor that watches cfg_req / RESET_FABRIC transitions.
module tb_warmboot_ctrl;

   localparam int LAT  = 6;
   localparam int RLEN = 16;
   localparam int K_REQ_RISE = 0;
   localparam int K_FAB_RISE = 1;
   localparam int K_REQ_FALL = 2;
   localparam int K_FAB_FALL = 3;

   typedef struct {
      int         kind;
      int         edge_n;
      logic [3:0] slot;
   } ev_t;

   ev_t  exp_q[$];
   logic CLK   = 1'b0;
   logic RESET = 1'b1;
   int   e      = 0;
   int   n_vec  = 0;
   int   n_miss = 0;
   int   k;
   int   a;

   warmboot_ctrl_if bus_if();

   warmboot_ctrl #(
      .SYNC_STAGES (2),
      .HOLD_CYCLES (4),
      .RESET_CYCLES(16),
      .NUM_SLOTS   (4)
   ) dut (
      .CLK  (CLK),
      .RESET(RESET),
      .bus  (bus_if.slave)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, e);
      end
   endtask

   task automatic push(input int kind, input int edge_n, input logic [3:0] slot);
      ev_t ev;
      ev.kind   = kind;
      ev.edge_n = edge_n;
      ev.slot   = slot;
      exp_q.push_back(ev);
   endtask

   task automatic wait_to_edge(input int n);
      while (e < n) @(negedge CLK);
   endtask

   task automatic observe(input int kind);
      ev_t ev;
      n_vec++;
      if (exp_q.size() == 0) begin
         n_miss++;
         $display("FAIL unexpected_event: got kind %0d at edge %0d slot %0d, expected none",
                  kind, e, bus_if.cfg_slot);
      end else begin
         ev = exp_q.pop_front();
         if (ev.kind != kind || ev.edge_n != e || ev.slot !== bus_if.cfg_slot) begin
            n_miss++;
            $display("FAIL event: got kind %0d edge %0d slot %0d, expected kind %0d edge %0d slot %0d",
                     kind, e, bus_if.cfg_slot, ev.kind, ev.edge_n, ev.slot);
         end
      end
   endtask

   // Monitor: counts edges and reports output transitions to the scoreboard
   initial begin
      logic pr;
      logic pf;
      pr = 1'b0;
      pf = 1'b0;
      forever begin
         @(posedge CLK);
         e = e + 1;
         #1;
         if (!pr && bus_if.cfg_req === 1'b1)      observe(K_REQ_RISE);
         if (!pf && bus_if.RESET_FABRIC === 1'b1) observe(K_FAB_RISE);
         if (pr && bus_if.cfg_req === 1'b0)       observe(K_REQ_FALL);
         if (pf && bus_if.RESET_FABRIC === 1'b0)  observe(K_FAB_FALL);
         pr = (bus_if.cfg_req === 1'b1);
         pf = (bus_if.RESET_FABRIC === 1'b1);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, edge %0d", e);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus_if.BOOT    = 1'b0;
      bus_if.SLOT    = 4'd0;
      bus_if.cfg_ack = 1'b0;
      wait_to_edge(3);
      RESET = 1'b0;
      check("rst_cfg_req", bus_if.cfg_req, 1'b0);
      check("rst_cfg_slot", bus_if.cfg_slot, 4'd0);
      check("rst_fabric", bus_if.RESET_FABRIC, 1'b0);
      check("rst_busy", bus_if.busy, 1'b0);
      check("rst_err", bus_if.err, 1'b0);

      // Normal request, slot 2, BOOT held 20 cycles, ack 3 cycles after req
      bus_if.SLOT = 4'd2;
      wait_to_edge(e + 3);
      bus_if.BOOT = 1'b1;
      k = e + 1;
      a = k + LAT + 3;
      push(K_REQ_RISE, k + LAT, 4'd2);
      push(K_FAB_RISE, k + LAT, 4'd2);
      push(K_REQ_FALL, a, 4'd2);
      push(K_FAB_FALL, a + RLEN, 4'd2);
      wait_to_edge(a - 1);
      bus_if.cfg_ack = 1'b1;
      wait_to_edge(a);
      bus_if.cfg_ack = 1'b0;
      wait_to_edge(k + 19);
      bus_if.BOOT = 1'b0;
      wait_to_edge(a + 20);
      check("t1_busy_idle", bus_if.busy, 1'b0);
      check("t1_slot_kept", bus_if.cfg_slot, 4'd2);

      // Glitch: BOOT high only 3 cycles
      bus_if.SLOT = 4'd1;
      wait_to_edge(e + 3);
      bus_if.BOOT = 1'b1;
      k = e + 1;
      wait_to_edge(k + 2);
      bus_if.BOOT = 1'b0;
      wait_to_edge(k + 3);
      check("t2_busy_arm", bus_if.busy, 1'b1);
      wait_to_edge(k + 10);
      check("t2_busy_idle", bus_if.busy, 1'b0);
      check("t2_slot_unch", bus_if.cfg_slot, 4'd2);
      check("t2_no_req", bus_if.cfg_req, 1'b0);

      // Ack held high from IDLE: nothing in IDLE, one-cycle request
      bus_if.cfg_ack = 1'b1;
      wait_to_edge(e + 5);
      check("t3_ack_idle", bus_if.busy, 1'b0);
      wait_to_edge(e + 3);
      bus_if.BOOT = 1'b1;
      k = e + 1;
      push(K_REQ_RISE, k + LAT, 4'd1);
      push(K_FAB_RISE, k + LAT, 4'd1);
      push(K_REQ_FALL, k + LAT + 1, 4'd1);
      push(K_FAB_FALL, k + LAT + 1 + RLEN, 4'd1);
      wait_to_edge(k + 10);
      bus_if.BOOT    = 1'b0;
      bus_if.cfg_ack = 1'b0;
      wait_to_edge(k + 28);
      check("t3_busy_idle", bus_if.busy, 1'b0);

      // SLOT changes 2->3 during REQ
      bus_if.SLOT = 4'd2;
      wait_to_edge(e + 3);
      bus_if.BOOT = 1'b1;
      k = e + 1;
      a = k + LAT + 4;
      push(K_REQ_RISE, k + LAT, 4'd2);
      push(K_FAB_RISE, k + LAT, 4'd2);
      push(K_REQ_FALL, a, 4'd2);
      push(K_FAB_FALL, a + RLEN, 4'd2);
      wait_to_edge(k + LAT);
      bus_if.SLOT = 4'd3;
      wait_to_edge(a - 1);
      bus_if.cfg_ack = 1'b1;
      wait_to_edge(a);
      bus_if.cfg_ack = 1'b0;
      wait_to_edge(a + 2);
      bus_if.BOOT = 1'b0;
      wait_to_edge(a + 20);
      check("t4_slot_held", bus_if.cfg_slot, 4'd2);

      // RESET during RST abandons the request
      wait_to_edge(e + 1);
      bus_if.BOOT = 1'b1;
      k = e + 1;
      push(K_REQ_RISE, k + LAT, 4'd3);
      push(K_FAB_RISE, k + LAT, 4'd3);
      push(K_REQ_FALL, k + LAT + 1, 4'd3);
      push(K_FAB_FALL, k + 10, 4'd0);
      wait_to_edge(k + LAT);
      bus_if.cfg_ack = 1'b1;
      wait_to_edge(k + LAT + 1);
      bus_if.cfg_ack = 1'b0;
      wait_to_edge(k + 9);
      RESET       = 1'b1;
      bus_if.BOOT = 1'b0;
      wait_to_edge(k + 10);
      RESET = 1'b0;
      check("t5_req", bus_if.cfg_req, 1'b0);
      check("t5_fabric", bus_if.RESET_FABRIC, 1'b0);
      check("t5_busy", bus_if.busy, 1'b0);
      check("t5_slot", bus_if.cfg_slot, 4'd0);
      check("t5_err", bus_if.err, 1'b0);
      wait_to_edge(e + 3);
      bus_if.BOOT = 1'b1;
      k = e + 1;
      push(K_REQ_RISE, k + LAT, 4'd3);
      push(K_FAB_RISE, k + LAT, 4'd3);
      push(K_REQ_FALL, k + LAT + 1, 4'd3);
      push(K_FAB_FALL, k + LAT + 1 + RLEN, 4'd3);
      wait_to_edge(k + LAT);
      bus_if.cfg_ack = 1'b1;
      wait_to_edge(k + LAT + 1);
      bus_if.cfg_ack = 1'b0;
      bus_if.BOOT    = 1'b0;
      wait_to_edge(k + 28);

      // Out-of-range slot 9
      bus_if.SLOT = 4'd9;
      wait_to_edge(e + 3);
      bus_if.BOOT = 1'b1;
      k = e + 1;
`ifdef WARMBOOT_SLOT_CHECK_EN
      wait_to_edge(k + LAT + 1);
      check("t6_err_set", bus_if.err, 1'b1);
      check("t6_no_req", bus_if.cfg_req, 1'b0);
      check("t6_busy_wait", bus_if.busy, 1'b1);
      bus_if.BOOT = 1'b0;
      wait_to_edge(k + 12);
      check("t6_busy_idle", bus_if.busy, 1'b0);
      check("t6_err_sticky", bus_if.err, 1'b1);
      RESET = 1'b1;
      wait_to_edge(e + 1);
      RESET = 1'b0;
      check("t6_err_clr", bus_if.err, 1'b0);
`else
      a = k + LAT + 2;
      push(K_REQ_RISE, k + LAT, 4'd9);
      push(K_FAB_RISE, k + LAT, 4'd9);
      push(K_REQ_FALL, a, 4'd9);
      push(K_FAB_FALL, a + RLEN, 4'd9);
      wait_to_edge(a - 1);
      bus_if.cfg_ack = 1'b1;
      wait_to_edge(a);
      bus_if.cfg_ack = 1'b0;
      bus_if.BOOT    = 1'b0;
      wait_to_edge(a + 20);
      check("t6_err_zero", bus_if.err, 1'b0);
      check("t6_slot9", bus_if.cfg_slot, 4'd9);
`endif

      wait_to_edge(e + 5);
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
